// File: rtl/serial_adder_pkg.sv
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and helpers for the bit-serial adder.
//                state_t - controller states (IDLE, RUN, DONE)
//                cnt_w   - width of the bit counter for a given operand width
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The counter must be able to hold 0..WIDTH, so one bit more than
   // the index range alone would need when WIDTH is a power of two.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
//  Module      : full_adder_cell
//  Description : Single-bit combinational full adder.
//  Ports       : x, y, c_in  - addend bits and carry-in
//                s           - sum bit
//                c_out       - carry-out (majority of the three inputs)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_cell (
   input  logic x,
   input  logic y,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   assign s     = x ^ y ^ c_in;
   assign c_out = (x & y) | (x & c_in) | (y & c_in);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder. One full-adder cell and a carry
//                register process one bit per cycle, LSB first. Results and
//                flags stay registered until the next operation completes.
//  Parameters  : WIDTH (>= 2) operand and sum width
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                start         - request, sampled only when not busy
//                a, b, c_in    - operands and carry-in, captured on start
//                sub           - subtract select (only with SERIAL_SUB_EN)
//                busy          - high while bits are being processed
//                done          - one-cycle pulse, outputs just updated
//                sum, c_out    - registered result and carry-out
//                ovf           - registered two's complement overflow
//  Config      : `define SERIAL_SUB_EN adds the sub port (sum = a - b)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int CW = cnt_w(WIDTH);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   // Only WIDTH-1 partial bits need storing: the final bit comes straight
   // from the cell on the completing edge.
   logic [WIDTH-2:0] r_s_sh;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_c_out;
   logic             r_ovf;

   logic [WIDTH-1:0] w_b_load;
   logic             w_carry_load;
   logic             w_cell_s;
   logic             w_cell_c;
   logic [WIDTH-1:0] w_s_next;
   logic             w_last;

`ifdef SERIAL_SUB_EN
   // Subtraction as a + ~b + 1: invert B and force the initial carry.
   assign w_b_load     = sub ? ~b : b;
   assign w_carry_load = sub | c_in;
`else
   assign w_b_load     = b;
   assign w_carry_load = c_in;
`endif

   full_adder_cell u_cell (
      .x     (r_a_sh[0]),
      .y     (r_b_sh[0]),
      .c_in  (r_carry),
      .s     (w_cell_s),
      .c_out (w_cell_c)
   );

   assign w_s_next = {w_cell_s, r_s_sh};
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_s_sh  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_c_out <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= w_b_load;
                  r_carry <= w_carry_load;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               r_s_sh  <= w_s_next[WIDTH-1:1];
               r_carry <= w_cell_c;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  // On the MSB cycle r_carry still holds the carry into the
                  // MSB, so overflow is that carry XOR the final carry-out.
                  r_sum   <= w_s_next;
                  r_c_out <= w_cell_c;
                  r_ovf   <= r_carry ^ w_cell_c;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy  = (r_state == RUN);
   assign done  = (r_state == DONE);
   assign sum   = r_sum;
   assign c_out = r_c_out;
   assign ovf   = r_ovf;

endmodule

`default_nettype wire
